div_sequencer: RTL and testbench

- Iterative radix-2 divide controller for the RV32M DIV/DIVU/REM/REMU instructions in the execute stage.
- Accepts an operation from the E stage and holds the front of the pipeline with a stall while it iterates.
- Presents a one-cycle result beat that the E-stage result mux selects, then returns to idle.
- Handles the RISC-V divide-by-zero and signed-overflow cases on a fast path.

---
 rtl/div_sequencer.sv | 126 ++++++++++++
 tb/tb_div_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results taken directly without iterating.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartE,
  input  logic [1:0]       DivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             StallDiv,
  output logic             DivDoneE,
  output logic [WIDTH-1:0] DivResultE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_divisor, r_result;
  logic             r_qneg, r_rneg, r_is_rem;

  logic             w_signed, w_b_zero, w_ovf, w_special, w_accept;
  logic [WIDTH-1:0] w_a_abs, w_b_abs, w_special_res;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_final;

  assign w_signed  = ~DivOpE[0];
  assign w_b_zero  = (SrcBE == '0);
  assign w_ovf     = w_signed & (SrcAE == MIN_NEG) & (SrcBE == '1);
  assign w_special = w_b_zero | w_ovf;
  assign w_accept  = StartE & ~FlushE;
  assign w_a_abs   = (w_signed & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign w_b_abs   = (w_signed & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
  assign w_special_res = w_b_zero ? (DivOpE[1] ? SrcAE : '1)
                                  : (DivOpE[1] ? '0 : MIN_NEG);

  // Partial remainder stays below the divisor, so after the shift the
  // (WIDTH+1)-bit difference has its top bit set exactly when rem < divisor.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_divisor};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_final   = r_is_rem ? (r_rneg ? -w_rem_nxt : w_rem_nxt)
                              : (r_qneg ? -w_quo_nxt : w_quo_nxt);

  assign DivDoneE   = (r_state == DONE);
  assign DivResultE = r_result;

  always_comb begin
    w_state_nxt = r_state;
    StallDiv    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          StallDiv    = 1'b1;
          w_state_nxt = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        if (FlushE) begin
          w_state_nxt = IDLE;
        end else begin
          StallDiv = 1'b1;
          if (r_cnt == '0) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (rst) StallDiv = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_is_rem  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_special) begin
              r_result <= w_special_res;
            end else begin
              r_quo     <= w_a_abs;
              r_divisor <= w_b_abs;
              r_rem     <= '0;
              r_qneg    <= w_signed & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
              r_rneg    <= w_signed & SrcAE[WIDTH-1];
              r_is_rem  <= DivOpE[1];
              r_cnt     <= CW'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          if (!FlushE) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == '0) r_result <= w_final;
            else             r_cnt    <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table for single ops plus flush, reset and back-to-back sequences.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StartE = 1'b0;
  logic [1:0]  DivOpE = 2'b00;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        FlushE = 1'b0;
  logic        StallDiv, DivDoneE;
  logic [31:0] DivResultE;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .DivOpE(DivOpE), .SrcAE(SrcAE),
    .SrcBE(SrcBE), .FlushE(FlushE), .StallDiv(StallDiv), .DivDoneE(DivDoneE),
    .DivResultE(DivResultE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Cycle 0 is the cycle StartE is first presented; outputs sampled 1ns after the falling edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat, input string nm);
    int stall_n, stall_end, done_n, done_at;
    logic [31:0] res;
    stall_n = 0; stall_end = -1; done_n = 0; done_at = -1; res = '0;
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      StartE = (c == 0);
      if (c == 0) begin
        DivOpE = op; SrcAE = a; SrcBE = b;
      end else begin
        DivOpE = 2'($urandom); SrcAE = $urandom; SrcBE = $urandom;
      end
      #1;
      if (StallDiv) stall_n++;
      else if (stall_end < 0) stall_end = c;
      if (DivDoneE) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          res = DivResultE;
        end
      end
    end
    chk({nm, " stall_cycles"}, stall_n, lat);
    chk({nm, " stall_end"}, stall_end, lat);
    chk({nm, " done_cycle"}, done_at, lat);
    chk({nm, " done_pulses"}, done_n, 1);
    chk({nm, " result"}, res, exp_res);
  endtask

  initial begin
    int done_n, at1, at2;
    logic [31:0] res1, res2;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[6]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[10] = '{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33};
    vecs[11] = '{OP_REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33};
    vecs[12] = '{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33};
    vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[14] = '{OP_REMU, 32'd3,          32'd10,         32'd3,          33};

    // Reset: outputs cleared, StartE ignored while rst is high.
    StartE = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("reset StallDiv", 32'(StallDiv), 0);
    chk("reset DivDoneE", 32'(DivDoneE), 0);
    chk("reset DivResultE", DivResultE, 0);
    @(negedge clk);
    StartE = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));

    // Flush at cycle 10 of a DIV; new DIVU 9/3 at cycle 12 completes at cycle 45.
    done_n = 0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      StartE = (c == 0);
      DivOpE = OP_DIV; SrcAE = 32'd100; SrcBE = 32'd7;
      FlushE = (c == 10);
      #1;
      if (DivDoneE) done_n++;
      if (c == 9)  chk("flush pre StallDiv", 32'(StallDiv), 1);
      if (c == 10) chk("flush c10 StallDiv", 32'(StallDiv), 0);
      if (c == 11) chk("flush c11 StallDiv", 32'(StallDiv), 0);
    end
    FlushE = 1'b0;
    chk("flush no done", done_n, 0);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "after_flush");

    // Asynchronous reset between edges at cycle 20 of a DIVU.
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      StartE = (c == 0);
      DivOpE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7;
      #1;
    end
    chk("rst pre StallDiv", 32'(StallDiv), 1);
    chk("rst pre DivResultE", DivResultE, 3);
    #1 rst = 1'b1;
    #1;
    chk("rst mid StallDiv", 32'(StallDiv), 0);
    chk("rst mid DivDoneE", 32'(DivDoneE), 0);
    chk("rst mid DivResultE", DivResultE, 0);
    #1 rst = 1'b0;
    done_n = 0;
    for (int c = 21; c <= 40; c++) begin
      @(negedge clk);
      #1;
      if (DivDoneE) done_n++;
    end
    chk("rst no done", done_n, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "after_rst");

    // Back-to-back with StartE held high and SrcAE churned during CALC.
    done_n = 0; at1 = -1; at2 = -1; res1 = '0; res2 = '0;
    for (int c = 0; c <= 68; c++) begin
      @(negedge clk);
      StartE = (c < 67);
      if (c == 0) begin
        DivOpE = OP_DIVU; SrcAE = 32'hFFFF_FFFF; SrcBE = 32'd1;
      end else if (c == 33 || c == 34) begin
        DivOpE = OP_REMU; SrcAE = 32'd10; SrcBE = 32'd4;
      end else begin
        SrcAE = $urandom;
      end
      #1;
      if (c == 33) chk("b2b c33 StallDiv", 32'(StallDiv), 0);
      if (c == 34) chk("b2b c34 StallDiv", 32'(StallDiv), 1);
      if (DivDoneE) begin
        done_n++;
        if (done_n == 1) begin at1 = c; res1 = DivResultE; end
        if (done_n == 2) begin at2 = c; res2 = DivResultE; end
      end
    end
    StartE = 1'b0;
    chk("b2b done_pulses", done_n, 2);
    chk("b2b first cycle", at1, 33);
    chk("b2b first result", res1, 32'hFFFF_FFFF);
    chk("b2b second cycle", at2, 67);
    chk("b2b second result", res2, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
